uart_bus_master: RTL and testbench

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master_if.sv | 17 +
 rtl/uart_bus_master.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_master_if.sv
// rtl/uart_bus_master_if.sv - memory-mapped bus port driven by the UART bus master
//
// Signals:
//   mWrite  [3:0]  byte write strobes (all four asserted for a write beat)
//   mAddr   [31:0] bus address
//   mWData  [31:0] bus write data
//   mRData  [31:0] bus read data, valid a fixed latency after mAddr
// Modports: master (bridge side), slave (memory/peripheral side).
interface uart_bus_master_if;
  logic [3:0]  mWrite;
  logic [31:0] mAddr;
  logic [31:0] mWData;
  logic [31:0] mRData;

  modport master (output mWrite, output mAddr, output mWData, input mRData);
  modport slave  (input mWrite, input mAddr, input mWData, output mRData);
endinterface

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART command bridge issuing single 32-bit bus reads/writes
//
// Frames on uart_rx: 'W' a0 a1 a2 a3 d0 d1 d2 d3 -> write, answered with 0x4B;
//                    'R' a0 a1 a2 a3             -> read, answered with 4 data bytes LSB first;
//                    anything else               -> answered with 0x3F.
// Ports:
//   clk      clock, posedge
//   rst_n    synchronous active-low reset
//   uart_rx  asynchronous serial input, idle high
//   uart_tx  serial output, idle high
//   busy     high whenever the command FSM is not idle
//   bus      uart_bus_master_if.master (mWrite/mAddr/mWData out, mRData in)
module uart_bus_master #(
  parameter int CLKS_PER_BIT = 234,
  parameter int RD_LATENCY   = 2,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uart_rx,
  output logic                      uart_tx,
  output logic                      busy,
  uart_bus_master_if.master         bus
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TMO_MAX = 32'(TIMEOUT_CLKS);
  localparam logic [1:0]  RD_LAT  = 2'(RD_LATENCY);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, SEND
  } state_t;

  state_t state, next_state;

  // ---------------- RX synchronizer ----------------
  logic rx_meta, rx_sync;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- RX deserializer ----------------
  // rx_idx: 0 = start bit, 1..8 = data, 9 = stop. The first sample lands half a
  // bit after the detected edge, later samples one full bit apart (mid-bit).
  // rx_armed is only set after the line is seen high, so a stuck-low line after
  // a framing error cannot retrigger a byte.
  logic        rx_busy, rx_armed, rx_valid;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_idx;
  logic [7:0]  rx_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_busy  <= 1'b0;
      rx_armed <= 1'b0;
      rx_valid <= 1'b0;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_armed && !rx_sync) begin
          rx_busy  <= 1'b1;
          rx_armed <= 1'b0;
          rx_cnt   <= '0;
          rx_idx   <= '0;
        end else if (rx_sync) begin
          rx_armed <= 1'b1;
        end
      end else if (rx_cnt == ((rx_idx == 4'd0) ? HALF_M1 : BIT_M1)) begin
        rx_cnt <= '0;
        rx_idx <= rx_idx + 4'd1;
        if (rx_idx == 4'd0) begin
          if (rx_sync) rx_busy <= 1'b0;            // start glitch
        end else if (rx_idx == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_sync) rx_valid <= 1'b1;           // stop=0 drops the byte
        end else begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
        end
      end else begin
        rx_cnt <= rx_cnt + 16'd1;
      end
    end
  end

  // ---------------- TX serializer ----------------
  // tx_idx counts the bit currently on the line: 0 start, 1..8 data, 9 stop.
  logic        tx_busy, tx_start;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_idx;
  logic [8:0]  tx_shift;
  logic [31:0] resp;
  logic [2:0]  resp_left;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '1;
      uart_tx  <= 1'b1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= {1'b1, resp[7:0]};
      uart_tx  <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_M1) begin
        tx_cnt <= '0;
        if (tx_idx == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          uart_tx  <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_idx   <= tx_idx + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  // ---------------- Command FSM ----------------
  logic [1:0]  byte_cnt;
  logic [1:0]  rd_cnt;
  logic [31:0] tmo;
  logic [31:0] addr_sh, data_sh;
  logic [31:0] m_addr, m_wdata;
  logic        cmd_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_shift == 8'h57 || rx_shift == 8'h52) next_state = GET_ADDR;
          else                                        next_state = SEND;
        end
      end
      GET_ADDR: begin
        if (rx_valid && byte_cnt == 2'd3) next_state = cmd_wr ? GET_DATA : BUS_RD;
        else if (!rx_valid && tmo >= TMO_MAX) next_state = IDLE;
      end
      GET_DATA: begin
        if (rx_valid && byte_cnt == 2'd3) next_state = BUS_WR;
        else if (!rx_valid && tmo >= TMO_MAX) next_state = IDLE;
      end
      BUS_WR: next_state = SEND;
      BUS_RD: begin
        if (rd_cnt == RD_LAT) next_state = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          if (resp_left != 3'd0) tx_start = 1'b1;
          else                   next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath. Address/data arrive little-endian, so each byte enters at the top
  // and four shifts leave the first byte in bits [7:0]. The fourth byte is merged
  // directly into the bus registers on the transition edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      rd_cnt    <= '0;
      tmo       <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      cmd_wr    <= 1'b0;
      resp      <= '0;
      resp_left <= '0;
    end else begin
      if (state == IDLE && rx_valid) cmd_wr <= (rx_shift == 8'h57);

      if (next_state != state)
        byte_cnt <= '0;
      else if (rx_valid && (state == GET_ADDR || state == GET_DATA))
        byte_cnt <= byte_cnt + 2'd1;

      if (next_state != state || rx_valid)             tmo <= '0;
      else if (state == GET_ADDR || state == GET_DATA) tmo <= tmo + 32'd1;
      else                                             tmo <= '0;

      if (state == GET_ADDR && rx_valid) addr_sh <= {rx_shift, addr_sh[31:8]};
      if (state == GET_DATA && rx_valid) data_sh <= {rx_shift, data_sh[31:8]};

      if (state == GET_ADDR && next_state == BUS_RD)
        m_addr <= {rx_shift, addr_sh[31:8]};
      if (state == GET_DATA && next_state == BUS_WR) begin
        m_addr  <= addr_sh;
        m_wdata <= {rx_shift, data_sh[31:8]};
      end

      // rd_cnt is 0 in the first cycle mAddr is presented; capture at RD_LATENCY.
      if (state == BUS_RD) rd_cnt <= rd_cnt + 2'd1;
      else                 rd_cnt <= '0;

      if (next_state == SEND && state != SEND) begin
        case (state)
          BUS_WR: begin resp <= 32'h0000_004B; resp_left <= 3'd1; end
          BUS_RD: begin resp <= bus.mRData;    resp_left <= 3'd4; end
          default: begin resp <= 32'h0000_003F; resp_left <= 3'd1; end
        endcase
      end else if (tx_start) begin
        resp      <= {8'h00, resp[31:8]};
        resp_left <= resp_left - 3'd1;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign bus.mWrite = (state == BUS_WR) ? 4'b1111 : 4'b0000;
  assign bus.mAddr  = m_addr;
  assign bus.mWData = m_wdata;

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - directed self-checking bench for uart_bus_master
module tb_uart_bus_master;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_bus_master_if bus();

  uart_bus_master #(.CLKS_PER_BIT(CPB), .RD_LATENCY(2), .TIMEOUT_CLKS(80)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .busy   (busy),
    .bus    (bus)
  );

  // Bus slave model: two-cycle read pipeline, one known location.
  logic [31:0] rd_d1;
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_d1      <= 32'h0;
      bus.mRData <= 32'h0;
    end else begin
      rd_d1      <= (bus.mAddr == 32'h1000_0004) ? 32'h1234_5678 : 32'hBAD0_BAD0;
      bus.mRData <= rd_d1;
    end
  end

  // Write monitor.
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_strb = '0;
  always @(negedge clk) begin
    if (bus.mWrite !== 4'h0) begin
      wr_cnt++;
      wr_addr = bus.mAddr;
      wr_data = bus.mWData;
      wr_strb = bus.mWrite;
    end
  end

  // UART TX decoder: logs every byte seen on uart_tx.
  logic [7:0] tx_log [0:255];
  int         tx_n = 0;
  int         tx_ferr = 0;
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    b    = '0;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1) tx_ferr++;
        tx_log[tx_n[7:0]] = b;
        tx_n++;
        prev = 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  int tx_rd = 0;
  int wr_base = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bit_time();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      bit_time();
    end
    uart_rx = stop_bit;
    bit_time();
    uart_rx = 1'b1;
    if (!stop_bit) bit_time();
  endtask

  task automatic wait_tx(input string tag, input int n);
    int c;
    c = 0;
    while ((tx_n - tx_rd) < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(tx_n - tx_rd), 32'(n));
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, tx_log[tx_rd[7:0]]}, {24'h0, exp});
    tx_rd++;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_busy",    {31'h0, busy},    32'h0);
    check("rst_mwrite",  {28'h0, bus.mWrite}, 32'h0);
    check("rst_maddr",   bus.mAddr,  32'h0);
    check("rst_mwdata",  bus.mWData, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Write frame
    wr_base = wr_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1); send_byte(8'h32, 1'b1);
    send_byte(8'h54, 1'b1); send_byte(8'h76, 1'b1);
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
    wait_tx("wr_resp_count", 1);
    expect_tx("wr_resp", 8'h4B);
    check("wr_cycles", 32'(wr_cnt - wr_base), 32'd1);
    check("wr_strb",   {28'h0, wr_strb}, 32'hF);
    check("wr_addr",   wr_addr, 32'h7654_3210);
    check("wr_data",   wr_data, 32'hDEAD_BEEF);
    wait_idle("wr_idle", 20);

    // Read frame
    wr_base = wr_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    wait_tx("rd_resp_count", 4);
    expect_tx("rd_b0", 8'h78);
    expect_tx("rd_b1", 8'h56);
    expect_tx("rd_b2", 8'h34);
    expect_tx("rd_b3", 8'h12);
    check("rd_no_write", 32'(wr_cnt - wr_base), 32'd0);
    check("rd_maddr", bus.mAddr, 32'h1000_0004);
    wait_idle("rd_idle", 60);

    // Unknown command
    wr_base = wr_cnt;
    send_byte(8'h41, 1'b1);
    wait_tx("bad_resp_count", 1);
    expect_tx("bad_resp", 8'h3F);
    wait_idle("bad_idle_after_stop", 8);
    check("bad_no_write", 32'(wr_cnt - wr_base), 32'd0);
    check("bad_maddr_held", bus.mAddr, 32'h1000_0004);
    check("bad_tx_ferr", 32'(tx_ferr), 32'd0);

    // Timeout of a partial write, then a read is still answered
    wr_base = wr_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (100) @(negedge clk);
    check("tmo_idle", {31'h0, busy}, 32'h0);
    check("tmo_no_resp", 32'(tx_n - tx_rd), 32'd0);
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    wait_tx("tmo_rd_count", 4);
    expect_tx("tmo_rd_b0", 8'h78);
    expect_tx("tmo_rd_b1", 8'h56);
    expect_tx("tmo_rd_b2", 8'h34);
    expect_tx("tmo_rd_b3", 8'h12);
    check("tmo_no_write", 32'(wr_cnt - wr_base), 32'd0);
    wait_idle("tmo_rd_idle", 60);

    // Framing error: byte with stop=0 is dropped, receiver re-arms afterwards
    send_byte(8'h41, 1'b0);
    repeat (60) @(negedge clk);
    check("ferr_no_resp", 32'(tx_n - tx_rd), 32'd0);
    check("ferr_idle", {31'h0, busy}, 32'h0);
    send_byte(8'h41, 1'b1);
    wait_tx("ferr_rearm_count", 1);
    expect_tx("ferr_rearm_resp", 8'h3F);
    wait_idle("ferr_rearm_idle", 8);

    // Reset in the middle of a write frame
    wr_base = wr_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    send_byte(8'h57, 1'b1);
    send_byte(8'h57, 1'b1);
    repeat (150) @(negedge clk);
    check("mid_rst_no_write", 32'(wr_cnt - wr_base), 32'd0);
    check("mid_rst_no_resp",  32'(tx_n - tx_rd), 32'd0);
    check("mid_rst_uart_tx",  {31'h0, uart_tx}, 32'h1);
    check("mid_rst_idle",     {31'h0, busy}, 32'h0);

    // Reset while a response is being transmitted
    send_byte(8'h41, 1'b1);
    begin
      int c;
      c = 0;
      while (uart_tx !== 1'b0 && c < 200) begin
        @(negedge clk);
        c++;
      end
      check("txrst_started", {31'h0, uart_tx}, 32'h0);
    end
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("txrst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("txrst_busy",    {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("txrst_tx_held", {31'h0, uart_tx}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
